// File: rtl/ctrl_pipe_pkg.sv
// Shared constants for the control-word pipeline: default sizing and the
// bit positions of each field inside the 17-bit decoded control word.
package ctrl_pipe_pkg;

    localparam int W_DEF       = 17;
    localparam int NSTAGES_DEF = 3;
    localparam int MCLAT_DEF   = 32;

    // Field positions, MSB first: memtoreg down to sb.
    localparam int MEMTOREG_BIT   = 16;
    localparam int MEMWRITE_BIT   = 15;
    localparam int ALUSRC_BIT     = 14;
    localparam int REGDST_MSB     = 13;
    localparam int REGDST_LSB     = 12;
    localparam int REGWRITE_BIT   = 11;
    localparam int ALUCONTROL_MSB = 10;
    localparam int ALUCONTROL_LSB = 7;
    localparam int JAL_BIT        = 6;
    localparam int LB_BIT         = 5;
    localparam int MULTORDIV_BIT  = 4;
    localparam int HLWRITE_BIT    = 3;
    localparam int MFHL_MSB       = 2;
    localparam int MFHL_LSB       = 1;
    localparam int SB_BIT         = 0;

endpackage

// File: rtl/ctrl_pipe_if.sv
// Bundle of the ID-side inputs, hazard controls and pipeline outputs of ctrl_pipe.
interface ctrl_pipe_if
    import ctrl_pipe_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int NSTAGES = NSTAGES_DEF
);
    logic [W-1:0]         ctrlD;
    logic                 validD;
    logic                 multicycleD;
    logic [NSTAGES-1:0]   stall;
    logic [NSTAGES-1:0]   flush;
    logic [NSTAGES*W-1:0] ctrl_q;
    logic [NSTAGES-1:0]   valid_q;
    logic                 mc_busy;
    logic                 mc_stall;

    modport master (
        output ctrlD, validD, multicycleD, stall, flush,
        input  ctrl_q, valid_q, mc_busy, mc_stall
    );

    modport slave (
        input  ctrlD, validD, multicycleD, stall, flush,
        output ctrl_q, valid_q, mc_busy, mc_stall
    );
endinterface

// File: rtl/ctrl_stage.sv
// One pipeline register holding {valid, ctrl}; supports flush, stall and
// bubble insertion when the upstream register is stalled.
module ctrl_stage
    import ctrl_pipe_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         stall,
    input  logic         bubble,
    input  logic [W-1:0] ctrl_in,
    input  logic         valid_in,
    output logic [W-1:0] ctrl_q,
    output logic         valid_q
);
    logic [W:0] word_q;
    logic [W:0] word_d;

    always_comb begin
        word_d = word_q;
        if (flush) begin
            word_d = '0;
        end else if (stall) begin
            word_d = word_q;
        end else if (bubble || !valid_in) begin
            // An invalid slot never carries stray control bits downstream.
            word_d = '0;
        end else begin
            word_d = {1'b1, ctrl_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign ctrl_q  = word_q[W-1:0];
    assign valid_q = word_q[W];
endmodule

// File: rtl/ctrl_pipe.sv
// Control-word pipeline (ID/EX onward) plus the multicycle mult/div busy counter.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int NSTAGES = NSTAGES_DEF,
    parameter int MCLAT   = MCLAT_DEF
) (
    input logic       clk,
    input logic       reset,
    ctrl_pipe_if.slave bus
);
    localparam int CW = $clog2(MCLAT + 1);

    logic [W-1:0] stage_ctrl  [NSTAGES];
    logic         stage_valid [NSTAGES];

    generate
        for (genvar gi = 0; gi < NSTAGES; gi++) begin : g_stage
            logic [W-1:0] src_ctrl;
            logic         src_valid;
            logic         bubble;

            if (gi == 0) begin : g_first
                assign src_ctrl  = bus.ctrlD;
                assign src_valid = bus.validD;
                assign bubble    = 1'b0;
            end else begin : g_rest
                assign src_ctrl  = stage_ctrl[gi-1];
                assign src_valid = stage_valid[gi-1];
                assign bubble    = bus.stall[gi-1];
            end

            ctrl_stage #(.W(W)) u_stage (
                .clk      (clk),
                .reset    (reset),
                .flush    (bus.flush[gi]),
                .stall    (bus.stall[gi]),
                .bubble   (bubble),
                .ctrl_in  (src_ctrl),
                .valid_in (src_valid),
                .ctrl_q   (stage_ctrl[gi]),
                .valid_q  (stage_valid[gi])
            );

            assign bus.ctrl_q[gi*W +: W] = stage_ctrl[gi];
            assign bus.valid_q[gi]       = stage_valid[gi];
        end
    endgenerate

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          mc_start;

    // The count is only (re)armed when the instruction actually enters ID/EX;
    // later flushes leave it running since the hi/lo write is already committed.
    assign mc_start = bus.validD & bus.multicycleD & ~bus.flush[0] & ~bus.stall[0];

    always_comb begin
        count_d = count_q;
        if (mc_start) begin
            count_d = CW'(MCLAT - 1);
        end else if (count_q != '0) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.mc_busy  = (count_q != '0);
    assign bus.mc_stall = bus.mc_busy & bus.validD & bus.multicycleD;
endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed-vector scoreboard bench for ctrl_pipe (W=17, NSTAGES=3, MCLAT=4).
module tb_ctrl_pipe;
    localparam int W  = 17;
    localparam int NS = 3;

    typedef struct {
        int              idx;
        logic            rst;
        logic [W-1:0]    ctrl;
        logic            v;
        logic            mc;
        logic [NS-1:0]   st;
        logic [NS-1:0]   fl;
        logic [NS*W-1:0] ectrl;
        logic [NS-1:0]   ev;
        logic            eb;
        logic            es;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ctrl_pipe_if #(.W(W), .NSTAGES(NS)) bus ();

    ctrl_pipe #(.W(W), .NSTAGES(NS), .MCLAT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    vec_t vecs  [$];
    vec_t exp_q [$];
    int   tests = 0;
    int   fails = 0;

    task automatic add(input logic r, input logic [W-1:0] c, input logic v, input logic mc,
                       input logic [NS-1:0] st, input logic [NS-1:0] fl,
                       input logic [W-1:0] e0, input logic [W-1:0] e1, input logic [W-1:0] e2,
                       input logic [NS-1:0] ev, input logic eb, input logic es);
        vec_t t;
        t.idx = vecs.size();
        t.rst = r; t.ctrl = c; t.v = v; t.mc = mc; t.st = st; t.fl = fl;
        t.ectrl = {e2, e1, e0}; t.ev = ev; t.eb = eb; t.es = es;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, expv);
        end
    endtask

    // Monitor: compare DUT outputs one step after each capture edge.
    initial begin
        vec_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("ctrl_q",   e.idx, 64'(bus.ctrl_q),   64'(e.ectrl));
                check("valid_q",  e.idx, 64'(bus.valid_q),  64'(e.ev));
                check("mc_busy",  e.idx, 64'(bus.mc_busy),  64'(e.eb));
                check("mc_stall", e.idx, 64'(bus.mc_stall), 64'(e.es));
                $display("[TB] vec %0d rst=%0b ctrlD=%h v=%0b mc=%0b st=%b fl=%b -> ctrl_q=%h valid_q=%b busy=%0b mc_stall=%0b",
                         e.idx, e.rst, e.ctrl, e.v, e.mc, e.st, e.fl,
                         bus.ctrl_q, bus.valid_q, bus.mc_busy, bus.mc_stall);
            end
        end
    end

    // Driver
    initial begin
        bus.ctrlD = '0; bus.validD = 1'b0; bus.multicycleD = 1'b0;
        bus.stall = '0; bus.flush = '0;

        //   rst ctrlD     v  mc st      fl      r0        r1        r2        valid   busy stall
        add(1, 17'h00000, 0, 0, 3'b000, 3'b000, 17'h0,    17'h0,    17'h0,    3'b000, 0, 0);
        add(1, 17'h1ABCD, 1, 1, 3'b111, 3'b000, 17'h0,    17'h0,    17'h0,    3'b000, 0, 0);
        add(0, 17'h1ABCD, 1, 0, 3'b000, 3'b000, 17'h1ABCD,17'h0,    17'h0,    3'b001, 0, 0);
        add(0, 17'h00000, 0, 0, 3'b000, 3'b000, 17'h0,    17'h1ABCD,17'h0,    3'b010, 0, 0);
        add(0, 17'h00000, 0, 0, 3'b000, 3'b000, 17'h0,    17'h0,    17'h1ABCD,3'b100, 0, 0);
        add(0, 17'h00000, 0, 0, 3'b000, 3'b000, 17'h0,    17'h0,    17'h0,    3'b000, 0, 0);
        add(0, 17'h1FFFF, 0, 0, 3'b000, 3'b000, 17'h0,    17'h0,    17'h0,    3'b000, 0, 0);
        add(0, 17'h000FF, 1, 0, 3'b000, 3'b000, 17'h000FF,17'h0,    17'h0,    3'b001, 0, 0);
        add(0, 17'h01234, 1, 0, 3'b001, 3'b001, 17'h0,    17'h0,    17'h0,    3'b000, 0, 0);
        add(0, 17'h000FF, 1, 0, 3'b000, 3'b000, 17'h000FF,17'h0,    17'h0,    3'b001, 0, 0);
        add(0, 17'h01111, 1, 0, 3'b001, 3'b000, 17'h000FF,17'h0,    17'h0,    3'b001, 0, 0);
        add(0, 17'h00000, 0, 0, 3'b000, 3'b000, 17'h0,    17'h000FF,17'h0,    3'b010, 0, 0);
        add(0, 17'h00000, 0, 0, 3'b000, 3'b000, 17'h0,    17'h0,    17'h000FF,3'b100, 0, 0);
        add(0, 17'h00000, 0, 0, 3'b000, 3'b000, 17'h0,    17'h0,    17'h0,    3'b000, 0, 0);
        add(0, 17'h0AAAA, 1, 0, 3'b000, 3'b000, 17'h0AAAA,17'h0,    17'h0,    3'b001, 0, 0);
        add(0, 17'h05555, 1, 0, 3'b000, 3'b000, 17'h05555,17'h0AAAA,17'h0,    3'b011, 0, 0);
        add(0, 17'h00000, 0, 0, 3'b010, 3'b000, 17'h0,    17'h0AAAA,17'h0,    3'b010, 0, 0);
        add(0, 17'h00000, 0, 0, 3'b000, 3'b000, 17'h0,    17'h0,    17'h0AAAA,3'b100, 0, 0);
        add(0, 17'h00000, 0, 0, 3'b000, 3'b100, 17'h0,    17'h0,    17'h0,    3'b000, 0, 0);
        add(0, 17'h00010, 1, 1, 3'b000, 3'b000, 17'h00010,17'h0,    17'h0,    3'b001, 1, 1);
        add(0, 17'h00000, 0, 0, 3'b000, 3'b000, 17'h0,    17'h00010,17'h0,    3'b010, 1, 0);
        add(0, 17'h00010, 1, 1, 3'b001, 3'b000, 17'h0,    17'h0,    17'h00010,3'b100, 1, 1);
        add(0, 17'h00010, 1, 1, 3'b001, 3'b000, 17'h0,    17'h0,    17'h0,    3'b000, 0, 0);
        add(0, 17'h00010, 1, 1, 3'b000, 3'b000, 17'h00010,17'h0,    17'h0,    3'b001, 1, 1);
        add(0, 17'h00000, 0, 0, 3'b000, 3'b111, 17'h0,    17'h0,    17'h0,    3'b000, 1, 0);
        add(0, 17'h00010, 1, 1, 3'b000, 3'b000, 17'h00010,17'h0,    17'h0,    3'b001, 1, 1);
        add(0, 17'h00000, 0, 0, 3'b000, 3'b000, 17'h0,    17'h00010,17'h0,    3'b010, 1, 0);
        add(0, 17'h00000, 0, 0, 3'b000, 3'b000, 17'h0,    17'h0,    17'h00010,3'b100, 1, 0);
        add(0, 17'h00000, 0, 0, 3'b000, 3'b000, 17'h0,    17'h0,    17'h0,    3'b000, 0, 0);
        add(0, 17'h00010, 1, 1, 3'b000, 3'b001, 17'h0,    17'h0,    17'h0,    3'b000, 0, 0);
        add(0, 17'h00001, 1, 0, 3'b000, 3'b000, 17'h00001,17'h0,    17'h0,    3'b001, 0, 0);
        add(0, 17'h00002, 1, 1, 3'b000, 3'b000, 17'h00002,17'h00001,17'h0,    3'b011, 1, 1);
        add(0, 17'h00003, 1, 0, 3'b000, 3'b000, 17'h00003,17'h00002,17'h00001,3'b111, 1, 0);
        add(1, 17'h00004, 1, 1, 3'b000, 3'b000, 17'h0,    17'h0,    17'h0,    3'b000, 0, 0);
        add(0, 17'h00000, 0, 0, 3'b000, 3'b000, 17'h0,    17'h0,    17'h0,    3'b000, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset           = vecs[i].rst;
            bus.ctrlD       = vecs[i].ctrl;
            bus.validD      = vecs[i].v;
            bus.multicycleD = vecs[i].mc;
            bus.stall       = vecs[i].st;
            bus.flush       = vecs[i].fl;
            exp_q.push_back(vecs[i]);
        end

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 SHALL have parameter W, default 17, width of one control word.
REQ-002 SHALL have parameter NSTAGES, default 3, number of pipeline registers (ID/EX, EX/MEM, MEM/WB); legal range 1..8.
REQ-003 SHALL have parameter MCLAT, default 32, multicycle (mult/div) latency in cycles; legal range 1..64.
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 ctrlD  in  W  decoded control word from the ID stage.
REQ-007 validD  in  1  ctrlD holds a real instruction.
REQ-008 multicycleD  in  1  the ID instruction starts a multicycle operation, or reads its result.
REQ-009 stall  in  NSTAGES  per-register hold; bit k controls register k, bit 0 is ID/EX.
REQ-010 flush  in  NSTAGES  per-register bubble insert; bit k controls register k.
REQ-011 ctrl_q  out  NSTAGES*W  register k output occupies bits [k*W +: W].
REQ-012 valid_q  out  NSTAGES  valid bit of register k.
REQ-013 mc_busy  out  1  a multicycle operation is in progress.
REQ-014 mc_stall  out  1  request to the hazard unit to hold ID.

Function
REQ-015 Register k SHALL load from register k-1 each edge (register 0 from ctrlD/validD); 1-cycle latency per register.
REQ-016 Per-register priority SHALL be: reset > flush[k] > stall[k] > advance.
REQ-017 flush[k] SHALL load ctrl 0 and valid 0 into register k.
REQ-018 stall[k] SHALL hold register k contents unchanged.
REQ-019 If stall[k-1]=1 and stall[k]=0, register k SHALL load a bubble (ctrl 0, valid 0), never a duplicate.
REQ-020 A register loading valid 0 SHALL store ctrl 0, whatever the source word holds.
REQ-021 Counter width SHALL be $clog2(MCLAT+1); mc_busy SHALL equal (count != 0).
REQ-022 When register 0 advances with validD=1, multicycleD=1 and flush[0]=0, count SHALL load MCLAT-1.
REQ-023 Otherwise count SHALL decrement by 1 per cycle while nonzero and SHALL saturate at 0.
REQ-024 With MCLAT=1, mc_busy SHALL never assert.
REQ-025 flush of any register SHALL NOT abort a running count, because the hi/lo write is committed.
REQ-026 mc_stall SHALL be combinational: mc_busy & validD & multicycleD.
REQ-027 A multicycle start while mc_busy=1 (hazard unit ignored mc_stall) SHALL restart the count at MCLAT-1.

Reset
REQ-028 On a reset edge, every register SHALL take ctrl 0 and valid 0, and count SHALL take 0.
REQ-029 Reset SHALL override concurrent stall, flush and multicycle start.
REQ-030 After reset, all outputs SHALL read 0 until new input propagates.
REQ-031 Reset asserted mid-operation SHALL drop all in-flight words and any running count.

Structure
REQ-032 Package ctrl_pipe_pkg SHALL hold the default W/NSTAGES/MCLAT constants.
REQ-033 ctrl_pipe_pkg SHALL hold the control-field bit-position constants: memtoreg, memwrite, alusrc, regdst[1:0], regwrite, alucontrol[3:0], jal, lb, multordiv, hlwrite, mfhl[1:0], sb.
REQ-034 One sub-module, ctrl_stage (a W+1-bit register with reset/flush/stall/bubble), SHALL be instantiated NSTAGES times by generate.
REQ-035 The multicycle counter SHALL stay in ctrl_pipe.

Verification (W=17, NSTAGES=3, MCLAT=4)
REQ-036 ctrlD=17'h1ABCD, validD=1 for one cycle, no stall/flush -> h1ABCD on reg0 at edge+1, reg1 at +2, reg2 at +3; each register reads 0 one cycle after.
REQ-037 Reg0 valid with h00FF, stall=3'b001, flush=3'b001 same cycle -> reg0=0, valid_q[0]=0; then stall=3'b001 alone with reg0=h00FF -> reg0 holds h00FF, reg1 gets 0 / valid 0.
REQ-038 ctrlD=17'h1FFFF, validD=0 -> reg0 ctrl=0, valid 0.
REQ-039 multicycleD=1, validD=1 at edge 0 -> mc_busy=1 after edges 0,1,2, 0 after edge 3; second multicycleD during busy -> mc_stall=1; after edge 3 -> mc_stall=0.
REQ-040 All registers valid, count=2, reset pulsed one cycle -> all ctrl_q, valid_q, mc_busy = 0 on the next edge.
